spi_apb_master: RTL and testbench

SPI_APB_MASTER -- requirements
Module: spi_apb_master

---
 rtl/spi_apb_master.sv | 152 +++++++++++++++
 tb/tb_spi_apb_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_master.sv
// rtl/spi_apb_master.sv - single-outstanding APB master fed by a command/response handshake
// Optional ACCESS wait timeout is compiled in with SPI_APB_MASTER_TIMEOUT_EN.
module spi_apb_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       PCLK,
   input  logic       PRESET_n,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_write_i,
   input  logic [2:0] cmd_addr_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_err_o,
   output logic       rsp_timeout_o,
   output logic [7:0] err_count_o,
   output logic       busy_o,
   output logic       PSEL_o,
   output logic       PENABLE_o,
   output logic       PWRITE_o,
   output logic [2:0] PADDR_o,
   output logic [7:0] PWDATA_o,
   input  logic [7:0] PRDATA_i,
   input  logic       PREADY_i,
   input  logic       PSLVERR_i
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_accept;
   logic       w_done;
   logic       w_abort;
   logic       w_err_event;
   logic       r_pwrite;
   logic [2:0] r_paddr;
   logic [7:0] r_pwdata;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_rdata;
   logic       r_rsp_err;
   logic [7:0] r_err_count;

   assign w_accept    = cmd_valid_i && cmd_ready_o;
   assign w_done      = (r_state == S_ACCESS) && PREADY_i;
   assign w_err_event = (w_done && PSLVERR_i) || w_abort;

`ifdef SPI_APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] r_wait_cnt;
   logic       r_rsp_timeout;

   // A ready slave wins over a timeout that expires on the same edge.
   assign w_abort = (r_state == S_ACCESS) && !PREADY_i && (r_wait_cnt == TIMEOUT_LIMIT);

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         r_wait_cnt    <= 8'd0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (r_state == S_SETUP)
            r_wait_cnt <= 8'd0;
         else if ((r_state == S_ACCESS) && !PREADY_i)
            r_wait_cnt <= r_wait_cnt + 8'd1;
         if (w_done)
            r_rsp_timeout <= 1'b0;
         else if (w_abort)
            r_rsp_timeout <= 1'b1;
      end
   end

   assign rsp_timeout_o = r_rsp_timeout;
`else
   assign w_abort       = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      PSEL_o      = 1'b0;
      PENABLE_o   = 1'b0;
      busy_o      = 1'b0;
      cmd_ready_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready_o = PRESET_n;
            if (w_accept)
               w_next = S_SETUP;
         end
         S_SETUP: begin
            PSEL_o = 1'b1;
            busy_o = 1'b1;
            w_next = S_ACCESS;
         end
         S_ACCESS: begin
            PSEL_o    = 1'b1;
            PENABLE_o = 1'b1;
            busy_o    = 1'b1;
            if (w_done || w_abort)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         r_pwrite    <= 1'b0;
         r_paddr     <= 3'd0;
         r_pwdata    <= 8'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'd0;
         r_rsp_err   <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_rsp_valid <= w_done || w_abort;
         if (w_accept) begin
            r_pwrite <= cmd_write_i;
            r_paddr  <= cmd_addr_i;
            r_pwdata <= cmd_wdata_i;
         end
         if (w_done) begin
            if (!r_pwrite)
               r_rsp_rdata <= PRDATA_i;
            r_rsp_err <= PSLVERR_i;
         end else if (w_abort) begin
            r_rsp_rdata <= 8'd0;
            r_rsp_err   <= 1'b1;
         end
         if (w_err_event && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
      end
   end

   assign PWRITE_o    = r_pwrite;
   assign PADDR_o     = r_paddr;
   assign PWDATA_o    = r_pwdata;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rsp_rdata;
   assign rsp_err_o   = r_rsp_err;
   assign err_count_o = r_err_count;

endmodule

// File: tb/tb_spi_apb_master.sv
// tb/tb_spi_apb_master.sv - directed bench for spi_apb_master with a response scoreboard
// Exercises the timeout path when SPI_APB_MASTER_TIMEOUT_EN is defined.
module tb_spi_apb_master;

`ifdef SPI_APB_MASTER_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   logic       PCLK = 1'b0;
   logic       PRESET_n;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic       cmd_write_i;
   logic [2:0] cmd_addr_i;
   logic [7:0] cmd_wdata_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_rdata_o;
   logic       rsp_err_o;
   logic       rsp_timeout_o;
   logic [7:0] err_count_o;
   logic       busy_o;
   logic       PSEL_o;
   logic       PENABLE_o;
   logic       PWRITE_o;
   logic [2:0] PADDR_o;
   logic [7:0] PWDATA_o;
   logic [7:0] PRDATA_i;
   logic       PREADY_i;
   logic       PSLVERR_i;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       tout;
      logic [7:0] ecnt;
   } rsp_t;

   rsp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rdata = 8'd0;
   logic [7:0] exp_ecnt  = 8'd0;

   spi_apb_master #(.TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o), .err_count_o(err_count_o), .busy_o(busy_o),
      .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
      .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
      .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rsp(input logic [7:0] rd, input logic err, input logic tout);
      rsp_t e;
      if (err && exp_ecnt != 8'hFF)
         exp_ecnt = exp_ecnt + 8'd1;
      e.rdata = rd;
      e.err   = err;
      e.tout  = tout;
      e.ecnt  = exp_ecnt;
      sb_q.push_back(e);
   endtask

   // Scoreboard: every response strobe must match the oldest expected entry.
   always @(negedge PCLK) begin
      if (rsp_valid_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 32'(sb_q.size()), 32'd1);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.tout));
            chk("err_count", 32'(err_count_o), 32'(e.ecnt));
         end
      end
   end

   // Called at #1 after a rising edge with the DUT in IDLE.
   task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                       input int nwait, input logic [7:0] rd, input logic slverr,
                       input logic hold_valid);
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = a;
      cmd_wdata_i = wd;
      PREADY_i    = 1'b0;
      PRDATA_i    = ~rd;
      PSLVERR_i   = ~slverr;
      chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
      @(posedge PCLK); #1;
      if (!hold_valid) cmd_valid_i = 1'b0;
      if (!wr) exp_rdata = rd;
      push_rsp(exp_rdata, slverr, 1'b0);
      chk("setup_psel", 32'(PSEL_o), 32'd1);
      chk("setup_penable", 32'(PENABLE_o), 32'd0);
      chk("setup_pwrite", 32'(PWRITE_o), 32'(wr));
      chk("setup_paddr", 32'(PADDR_o), 32'(a));
      chk("setup_pwdata", 32'(PWDATA_o), 32'(wd));
      chk("setup_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("setup_no_rsp", 32'(rsp_valid_o), 32'd0);
      @(posedge PCLK); #1;
      for (int i = 0; i < nwait; i++) begin
         chk("wait_penable", 32'(PENABLE_o), 32'd1);
         chk("wait_no_rsp", 32'(rsp_valid_o), 32'd0);
         @(posedge PCLK); #1;
      end
      chk("access_psel", 32'(PSEL_o), 32'd1);
      chk("access_penable", 32'(PENABLE_o), 32'd1);
      chk("access_paddr", 32'(PADDR_o), 32'(a));
      chk("access_pwdata", 32'(PWDATA_o), 32'(wd));
      chk("access_busy", 32'(busy_o), 32'd1);
      chk("access_no_rsp", 32'(rsp_valid_o), 32'd0);
      PREADY_i  = 1'b1;
      PRDATA_i  = rd;
      PSLVERR_i = slverr;
      @(posedge PCLK); #1;
      PREADY_i  = 1'b0;
      PRDATA_i  = 8'h3C;
      PSLVERR_i = 1'b1;
      chk("rsp_valid_latency", 32'(rsp_valid_o), 32'd1);
      chk("rsp_cycle_psel", 32'(PSEL_o), 32'd0);
      chk("idle_paddr_hold", 32'(PADDR_o), 32'(a));
   endtask

   initial begin
      PRESET_n    = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 3'd0;
      cmd_wdata_i = 8'd0;
      PRDATA_i    = 8'h00;
      PREADY_i    = 1'b0;
      PSLVERR_i   = 1'b0;
      @(posedge PCLK); #1;
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_psel", 32'(PSEL_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_err_count", 32'(err_count_o), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata_o), 32'd0);
      PRESET_n = 1'b1;
      @(posedge PCLK); #1;

      // Native slave write, then zero-wait read.
      xfer(1'b1, 3'd0, 8'h5C, 1, 8'h00, 1'b0, 1'b0);
      chk("write_rsp_err", 32'(rsp_err_o), 32'd0);
      @(posedge PCLK); #1;
      xfer(1'b0, 3'd4, 8'h00, 0, 8'hA7, 1'b0, 1'b0);
      chk("read_pwrite", 32'(PWRITE_o), 32'd0);
      @(posedge PCLK); #1;

      // cmd_valid held across completion: next accept happens in the rsp_valid cycle.
      xfer(1'b1, 3'd5, 8'h81, 2, 8'h00, 1'b0, 1'b1);
      xfer(1'b0, 3'd6, 8'h00, 1, 8'h4E, 1'b0, 1'b0);
      @(posedge PCLK); #1;

      // Reset during ACCESS.
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 3'd2;
      @(posedge PCLK); #1;
      cmd_valid_i = 1'b0;
      @(posedge PCLK); #1;
      chk("pre_rst_penable", 32'(PENABLE_o), 32'd1);
      PRESET_n = 1'b0;
      #1;
      chk("async_rst_psel", 32'(PSEL_o), 32'd0);
      chk("async_rst_penable", 32'(PENABLE_o), 32'd0);
      chk("async_rst_paddr", 32'(PADDR_o), 32'd0);
      chk("async_rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
      exp_rdata = 8'd0;
      exp_ecnt  = 8'd0;
      @(posedge PCLK); #1;
      PREADY_i = 1'b1;
      @(posedge PCLK); #1;
      PREADY_i = 1'b0;
      chk("in_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      PRESET_n = 1'b1;
      @(posedge PCLK); #1;
      chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      xfer(1'b0, 3'd3, 8'h00, 1, 8'h96, 1'b0, 1'b0);
      @(posedge PCLK); #1;

`ifdef SPI_APB_MASTER_TIMEOUT_EN
      begin
         int edges;
         edges = 0;
         cmd_valid_i = 1'b1;
         cmd_write_i = 1'b1;
         cmd_addr_i  = 3'd7;
         cmd_wdata_i = 8'h11;
         PREADY_i    = 1'b0;
         @(posedge PCLK); #1;
         cmd_valid_i = 1'b0;
         push_rsp(8'h00, 1'b1, 1'b1);
         exp_rdata = 8'h00;
         while (rsp_valid_o !== 1'b1 && edges < 40) begin
            @(posedge PCLK); #1;
            edges++;
         end
         chk("timeout_edges", 32'(edges), 32'(TO + 2));
         chk("timeout_psel", 32'(PSEL_o), 32'd0);
         @(posedge PCLK); #1;
      end
`endif

      // Error storm: counter must saturate at 255.
      for (int n = 0; n < 257; n++) begin
         xfer(1'b1, 3'(n), 8'(n), 0, 8'h00, 1'b1, 1'b0);
         chk("storm_rsp_err", 32'(rsp_err_o), 32'd1);
      end
      chk("err_count_sat", 32'(err_count_o), 32'd255);
      @(posedge PCLK); #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
